// File: rtl/tally_display_core_pkg.sv
// rtl/tally_display_core_pkg.sv - seven-segment codes and count limits for tally_display_core
//   seg_code(d): active-low {dp,g,f,e,d,c,b,a} pattern for decimal digit d, blank otherwise
package tally_display_core_pkg;

    localparam int DEFAULT_SUM_LIMIT = 100;
    localparam int TARGET_MAX        = 30;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_F     = 8'h8E;

    function automatic logic [7:0] seg_code(input logic [9:0] d);
        logic [7:0] code;
        case (d)
            10'd0:   code = SEG_0;
            10'd1:   code = SEG_1;
            10'd2:   code = SEG_2;
            10'd3:   code = SEG_3;
            10'd4:   code = SEG_4;
            10'd5:   code = SEG_5;
            10'd6:   code = SEG_6;
            10'd7:   code = SEG_7;
            10'd8:   code = SEG_8;
            10'd9:   code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tally_display_core_tick_divider.sv
// rtl/tally_display_core_tick_divider.sv - free-running divider emitting a one-clock tick every DIV clocks
//   clk  : system clock
//   rst  : synchronous active-high reset, counter to 0
//   tick : high for one clock while the counter sits at DIV-1
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/tally_display_core.sv
// rtl/tally_display_core.sv - fill/total counter and 8-digit seven-segment scanner for the bottle filler
//   clk, rst          : system clock, synchronous active-high reset
//   run, enable       : counting requested / permitted; counting only while both are high
//   target            : pills per bottle, legal 1..30
//   full              : shows F on the leftmost digit
//   now_num, sum_num  : pills in current bottle, saturating grand total
//   flag              : bottles completed in this run, saturating at 63
//   an, seg           : active-low one-hot digit enable and {dp,g,f,e,d,c,b,a} segments
module tally_display_core
    import tally_display_core_pkg::*;
#(
    parameter int COUNT_DIV = 100_000_000,
    parameter int SCAN_DIV  = 150_000,
    parameter int SUM_LIMIT = DEFAULT_SUM_LIMIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       enable,
    input  logic [5:0] target,
    input  logic       full,
    output logic [5:0] now_num,
    output logic [9:0] sum_num,
    output logic [5:0] flag,
    output logic [7:0] an,
    output logic [7:0] seg
);

    logic       count_tick;
    logic       scan_tick;
    logic [2:0] idx;
    logic       target_ok;
    logic       sum_sat;

    tick_divider #(.DIV(COUNT_DIV)) u_count_div (
        .clk  (clk),
        .rst  (rst),
        .tick (count_tick)
    );

    tick_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk  (clk),
        .rst  (rst),
        .tick (scan_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (scan_tick) begin
            idx <= idx + 3'd1;
        end
    end

    assign target_ok = (target != 6'd0) && (target <= 6'(TARGET_MAX));
    assign sum_sat   = (sum_num == 10'(SUM_LIMIT));

    // Dropping run/enable clears the bottle even on a tick edge; the total survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            now_num <= '0;
            sum_num <= '0;
            flag    <= '0;
        end else if (!(run && enable)) begin
            now_num <= '0;
            flag    <= '0;
        end else if (count_tick && target_ok && !sum_sat) begin
            sum_num <= sum_num + 10'd1;
            if (now_num + 6'd1 == target) begin
                now_num <= '0;
                if (flag != 6'd63) begin
                    flag <= flag + 6'd1;
                end
            end else begin
                now_num <= now_num + 6'd1;
            end
        end
    end

    always_comb begin
        an  = ~(8'd1 << idx);
        seg = SEG_BLANK;
        case (idx)
            3'd0:    seg = seg_code(10'(now_num % 6'd10));
            3'd1:    seg = seg_code(10'(now_num / 6'd10));
            3'd4:    seg = seg_code(sum_num % 10'd10);
            3'd5:    seg = seg_code((sum_num / 10'd10) % 10'd10);
            3'd6:    seg = seg_code(sum_num / 10'd100);
            3'd7:    seg = full ? SEG_F : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: tb/tb_tally_display_core.sv
// tb/tb_tally_display_core.sv - self-checking bench for tally_display_core
module tb_tally_display_core;

    localparam int COUNT_DIV = 4;
    localparam int SCAN_DIV  = 2;
    localparam int LIM_A     = 100;
    localparam int LIM_S     = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       enable = 1'b0;
    logic [5:0] target = 6'd3;
    logic       full = 1'b0;

    logic [5:0] now_o  [2];
    logic [9:0] sum_o  [2];
    logic [5:0] flag_o [2];
    logic [7:0] an_o   [2];
    logic [7:0] seg_o  [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    int cyc = 0;
    int m_now [2];
    int m_sum [2];
    int m_flag[2];
    int lim   [2] = '{LIM_A, LIM_S};

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [7:0] an_lit  [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] seg_lit [8]  = '{8'hF8, 8'hA4, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hF9, 8'h8E};
    int         fill_seq[7]  = '{1, 2, 0, 1, 2, 0, 1};

    always #5 clk = ~clk;

    tally_display_core #(.COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV), .SUM_LIMIT(LIM_A)) dut_a (
        .clk(clk), .rst(rst), .run(run), .enable(enable), .target(target), .full(full),
        .now_num(now_o[0]), .sum_num(sum_o[0]), .flag(flag_o[0]), .an(an_o[0]), .seg(seg_o[0])
    );

    tally_display_core #(.COUNT_DIV(COUNT_DIV), .SCAN_DIV(SCAN_DIV), .SUM_LIMIT(LIM_S)) dut_s (
        .clk(clk), .rst(rst), .run(run), .enable(enable), .target(target), .full(full),
        .now_num(now_o[1]), .sum_num(sum_o[1]), .flag(flag_o[1]), .an(an_o[1]), .seg(seg_o[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: cyc counts clock edges since reset release, so a count tick
    // is every COUNT_DIV-th edge and the displayed digit is (cyc / SCAN_DIV) mod 8.
    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            for (int k = 0; k < 2; k++) begin
                m_now[k] = 0; m_sum[k] = 0; m_flag[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!(run && enable)) begin
                    m_now[k] = 0;
                    m_flag[k] = 0;
                end else if ((cyc % COUNT_DIV) == COUNT_DIV - 1 && target >= 1 && target <= 30
                             && m_sum[k] < lim[k]) begin
                    m_sum[k]++;
                    if (m_now[k] + 1 == int'(target)) begin
                        m_now[k] = 0;
                        if (m_flag[k] < 63) m_flag[k]++;
                    end else begin
                        m_now[k]++;
                    end
                end
            end
            cyc++;
        end
    end

    function automatic logic [7:0] exp_seg(input int k, input int d);
        case (d)
            0: return seg_tab[m_now[k] % 10];
            1: return seg_tab[m_now[k] / 10];
            4: return seg_tab[m_sum[k] % 10];
            5: return seg_tab[(m_sum[k] / 10) % 10];
            6: return seg_tab[m_sum[k] / 100];
            7: return full ? 8'h8E : 8'hFF;
            default: return 8'hFF;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                int d;
                d = (cyc / SCAN_DIV) % 8;
                chk($sformatf("model_now[%0d]", k), int'(now_o[k]), m_now[k]);
                chk($sformatf("model_sum[%0d]", k), int'(sum_o[k]), m_sum[k]);
                chk($sformatf("model_flag[%0d]", k), int'(flag_o[k]), m_flag[k]);
                chk($sformatf("model_an[%0d]", k), int'(an_o[k]), int'(~(8'd1 << d)) & 8'hFF);
                chk($sformatf("model_seg[%0d]", k), int'(seg_o[k]), int'(exp_seg(k, d)));
            end
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clocks(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        clocks(2);
        chk("rst_now", int'(now_o[0]), 0);
        chk("rst_sum", int'(sum_o[0]), 0);
        chk("rst_flag", int'(flag_o[0]), 0);
        chk("rst_an", int'(an_o[0]), 8'hFE);
        chk("rst_seg", int'(seg_o[0]), 8'hC0);
        check_en = 1'b1;

        // Fill with target 3; first tick lands on the 4th edge after release
        rst = 1'b0; run = 1'b1; enable = 1'b1; target = 6'd3;
        clocks(3);
        chk("pre_tick_now", int'(now_o[0]), 0);
        for (int i = 0; i < 7; i++) begin
            clocks(i == 0 ? 1 : COUNT_DIV);
            chk($sformatf("fill_now_%0d", i), int'(now_o[0]), fill_seq[i]);
        end
        chk("fill_flag", int'(flag_o[0]), 2);
        chk("fill_sum", int'(sum_o[0]), 7);

        // Stop mid-bottle at sum 5, drop coinciding with a tick edge
        do_reset();
        clocks(5 * COUNT_DIV);
        chk("stop_pre_now", int'(now_o[0]), 2);
        chk("stop_pre_sum", int'(sum_o[0]), 5);
        chk("stop_pre_flag", int'(flag_o[0]), 1);
        clocks(COUNT_DIV - 1);
        enable = 1'b0;
        clocks(1);
        chk("stop_now", int'(now_o[0]), 0);
        chk("stop_flag", int'(flag_o[0]), 0);
        chk("stop_sum", int'(sum_o[0]), 5);

        // Illegal targets
        enable = 1'b1; target = 6'd0;
        clocks(5 * COUNT_DIV);
        chk("tgt0_now", int'(now_o[0]), 0);
        chk("tgt0_sum", int'(sum_o[0]), 5);
        target = 6'd31;
        clocks(5 * COUNT_DIV);
        chk("tgt31_now", int'(now_o[0]), 0);
        chk("tgt31_sum", int'(sum_o[0]), 5);

        // Saturation on the SUM_LIMIT=10 instance
        target = 6'd30;
        do_reset();
        clocks(15 * COUNT_DIV);
        chk("sat_sum", int'(sum_o[1]), 10);
        chk("sat_now", int'(now_o[1]), 10);
        chk("nosat_sum", int'(sum_o[0]), 15);
        chk("nosat_now", int'(now_o[0]), 15);

        // Bring dut_a to now 27, total 100
        clocks(58 * COUNT_DIV);
        chk("pre_drop_sum", int'(sum_o[0]), 73);
        chk("pre_drop_now", int'(now_o[0]), 13);
        enable = 1'b0;
        clocks(1);
        enable = 1'b1;
        chk("drop_now", int'(now_o[0]), 0);
        chk("drop_sum", int'(sum_o[0]), 73);
        clocks(150);
        chk("disp_now", int'(now_o[0]), 27);
        chk("disp_sum", int'(sum_o[0]), 100);
        chk("sat_now_after_drop", int'(now_o[1]), 0);
        full = 1'b1;

        // Scan through all 8 digits starting from digit 0
        begin
            int guard;
            guard = 0;
            while ((cyc % (8 * SCAN_DIV)) != 0 && guard < 32) begin
                clocks(1);
                guard++;
            end
            chk("scan_align_timeout", guard < 32 ? 1 : 0, 1);
        end
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("disp_an_%0d", s), int'(an_o[0]), int'(an_lit[s]));
            chk($sformatf("disp_seg_%0d", s), int'(seg_o[0]), int'(seg_lit[s]));
            clocks(SCAN_DIV);
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tally_display_core.md
# tally_display_core

Single-clock datapath and display core for the bottle-filling controller. It accepts a per-bottle target count and run/enable qualifiers from the control FSM. It advances a fill counter on a slow count tick and keeps a saturating grand total and a completed-bottle count. It drives an 8-digit multiplexed seven-segment display with the fill count, the total and a full indicator. It contains the count-tick divider, the fill/total counter and the display scanner.

## Interface
- `COUNT_DIV`, default 100_000_000: clocks per count tick (minimum 2).
- `SCAN_DIV`, default 150_000: clocks per display digit step (minimum 2).
- `SUM_LIMIT`, default 100: saturation value of `sum_num`.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: reset; synchronous, active-high.
- `run` in 1: counting requested by the control FSM.
- `enable` in 1: counting permitted (start switch AND not full).
- `target` in 6: pills per bottle, legal range 1..30.
- `full` in 1: full indicator for the display.
- `now_num` out 6: pills in the current bottle.
- `sum_num` out 10: grand total of pills.
- `flag` out 6: bottles completed in the current run.
- `an` out 8: digit enables, active-low, one-hot.
- `seg` out 8: segments, active-low, `{dp,g,f,e,d,c,b,a}`.

## Operation
- Count tick: free-running counter 0..COUNT_DIV-1. `tick` is 1 for one clock when the counter equals COUNT_DIV-1, then the counter wraps to 0.
- Scan tick: same scheme using SCAN_DIV. On each scan tick, the 3-bit digit index increments and wraps 7 to 0.
- Counter, priority order, evaluated each clock:
  - `rst`: `now_num`, `sum_num` and `flag` go to 0.
  - `!(run && enable)`: `now_num` and `flag` go to 0; `sum_num` holds.
  - `tick` with `target == 0` or `target > 30`: no change.
  - `tick` with `sum_num == SUM_LIMIT`: no change (saturated).
  - Otherwise on `tick`: `sum_num` increments by 1.
    - If `now_num+1 == target`, `now_num` goes to 0 and `flag` increments by 1, saturating at 63.
    - Else `now_num` increments by 1.
- Display: digit index i drives `an = ~(1<<i)`. The digit content is:
  - d0 = `now_num%10`, d1 = `now_num/10`.
  - d2, d3 = blank.
  - d4 = `sum_num%10`, d5 = `(sum_num/10)%10`, d6 = `sum_num/100`.
  - d7 = `F` when `full`, else blank.
- Segment codes for 0..9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex). Blank = FF, F = 8E. dp is always off.
- Decimal conversion is combinational on the registered counts; out-of-range values cannot occur because `sum_num` ≤ SUM_LIMIT ≤ 999.

## Timing
- Reset values:
  - `now_num` = 0, `sum_num` = 0, `flag` = 0.
  - Both divider counters 0; digit index 0.
  - `an` = FE, `seg` = C0.
- Counter outputs are registered and update on the clock edge that samples `tick`, so there is 1 clock of latency from the tick.
- `an`/`seg` are combinational from the registered index, counts and `full`.
- If a tick coincides with `run` or `enable` falling, the clear wins.
- A tick coincident with the batch-completing increment both zeroes `now_num` and increments `sum_num` in the same edge.
- Reset mid-operation clears everything regardless of tick.
- The dividers are not cleared by `run`/`enable`; only `rst` clears them.

## Structure
- Shared package: seven-segment code constants (digits 0-9, BLANK, F) and default `SUM_LIMIT` / target limit 30.
- One reusable sub-module, `tick_divider` (parameter DIV, outputs a one-clock pulse), instantiated twice: count tick and scan tick.
- Counter and display logic live in the top. No derived clocks: all logic runs on `clk` with enables.

## Test plan
- Reset: assert `rst` 2 clocks -> counts 0, `an`=FE, `seg`=C0. Tick fires exactly COUNT_DIV clocks after reset release (use COUNT_DIV=4).
- Fill: `target`=3, `run`=`enable`=1, 7 ticks -> `now_num` sequence 1,2,0,1,2,0,1; `flag`=2; `sum_num`=7.
- Saturation: SUM_LIMIT=10, `target`=30, 15 ticks -> `sum_num` stops at 10, `now_num` stops at 10.
- Illegal target: `target`=0 then 31, 5 ticks each -> no count change.
- Stop: drop `enable` mid-bottle with `sum_num`=5 -> `now_num`=0 and `flag`=0 next clock, `sum_num`=5 held. Tick coincident with drop -> no increment.
- Display (SCAN_DIV=2): `now_num`=27, `sum_num`=100, `full`=1, over 8 scan steps:
  - `an` FE, FD, FB, F7, EF, DF, BF, 7F.
  - `seg` F8, A4, FF, FF, C0, C0, F9, 8E.
